// File: rtl/imem_responder_pkg.sv
// rtl/imem_responder_pkg.sv - shared state encoding and constants for the instruction-memory responder
package imem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0000;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - DEPTH x 32 program storage, one write port and one enabled registered read port
module imem_array #(
  parameter int DEPTH = 64,
  parameter int IW    = 6
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [IW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];

  // Both ports update with non-blocking assignments, so a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fetch responder with configurable wait states, hold back to the PC and fault flags
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] NOP_WORD    = IMEM_NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        req,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] instruction,
  output logic        valid,
  output logic        hold,
  output logic        misaligned,
  output logic        out_of_range
);

  localparam int             IW        = idx_width(DEPTH);
  localparam int             CW        = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0]  CNT_LOAD  = CW'(WAIT_CYCLES);
  localparam logic           ZERO_WAIT = (WAIT_CYCLES == 0);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q;
  logic          nop_sel;
  logic [31:0]   rd_data;
  logic [31:0]   rd_addr;
  logic          accept, complete, rd_mis, rd_oor, wr_ok;
  logic          unused_wr_lsb;

  assign accept   = reset & ~flush & req & ((state == IDLE) | (state == RESP));
  // A fetch completes on the edge that enters RESP: straight from accept, or at the last wait state.
  assign complete = reset & ~flush & ((ZERO_WAIT & accept) | ((state == WAIT) & (cnt == CW'(1))));
  assign hold     = reset & ~flush & ((accept & ~ZERO_WAIT) | ((state == WAIT) & (cnt > CW'(1))));

  assign rd_addr = (state == WAIT) ? addr_q : address;
  assign rd_mis  = (rd_addr[1:0] != 2'b00);
  assign rd_oor  = (rd_addr[31:2] >= 30'(DEPTH));
  assign wr_ok   = wr_en & (wr_addr[31:2] < 30'(DEPTH));
  assign unused_wr_lsb = ^wr_addr[1:0];

  // Faulted or post-reset fetches present NOP_WORD without disturbing the stored read word.
  assign instruction = nop_sel ? NOP_WORD : rd_data;

  imem_array #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_idx  (wr_addr[IW+1:2]),
    .wr_data (wr_data),
    .rd_en   (complete & ~rd_mis & ~rd_oor),
    .rd_idx  (rd_addr[IW+1:2]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      valid        <= 1'b0;
      misaligned   <= 1'b0;
      out_of_range <= 1'b0;
      nop_sel      <= 1'b1;
    end else begin
      valid        <= complete;
      misaligned   <= complete & rd_mis;
      out_of_range <= complete & rd_oor;
      if (complete) nop_sel <= rd_mis | rd_oor;
      if (accept) addr_q <= address;
      if (flush) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE, RESP: begin
            if (accept) begin
              if (ZERO_WAIT) begin
                state <= RESP;
              end else begin
                state <= WAIT;
                cnt   <= CNT_LOAD;
              end
            end else begin
              state <= IDLE;
            end
          end
          WAIT: begin
            if (cnt == CW'(1)) begin
              state <= RESP;
              cnt   <= '0;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder on the fetch interface; the PC register is the initiator.
- Each cycle the PC presents a fetch address and a request. This block returns the instruction word after a configurable number of wait states.
- While a fetch is outstanding it drives `hold` back to the PC (and the IF/ID stall), so the PC advances only when its fetch completes.
- A side write port preloads program words, typically while the core is held in reset.

Parameters:
- DEPTH, 64, number of 32-bit instruction words stored; word index = address[7:2] at default.
- WAIT_CYCLES, 2, wait states per fetch (0 allowed = single-cycle memory).
- NOP_WORD, 32'h0000_0000, word returned on faults and after reset.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- address  input  32  fetch address from PC
- req  input  1  fetch request, qualifies address
- flush  input  1  abort outstanding fetch (taken branch/jump)
- wr_en  input  1  program-load write enable
- wr_addr  input  32  program-load byte address (word-aligned; bits [1:0] ignored)
- wr_data  input  32  program-load word
- instruction  output  32  fetched word (registered)
- valid  output  1  instruction valid, one-cycle pulse per completed fetch (registered)
- hold  output  1  to PC hold: fetch in progress, PC must not advance (combinational)
- misaligned  output  1  completed fetch had address[1:0] != 0; qualified by valid
- out_of_range  output  1  completed fetch word index >= DEPTH; qualified by valid

Behaviour:
- States:
  - IDLE: no fetch outstanding.
  - WAIT: counting wait states.
  - RESP: valid cycle; accepts a new request exactly like IDLE.
- Reset: reset=0 at posedge puts the block in state IDLE with wait counter = 0, instruction = NOP_WORD, valid = 0, misaligned = 0, out_of_range = 0. `hold` evaluates to 0 while reset is low. Memory contents are not cleared.
- Accept:
  - Occurs in IDLE or RESP with req=1 and flush=0. The address is latched.
  - If WAIT_CYCLES = 0, the next state is RESP.
  - Otherwise the next state is WAIT with counter = WAIT_CYCLES.
- WAIT:
  - The counter decrements each edge.
  - When counter = 1, the next state is RESP.
  - req is ignored in WAIT.
- hold equation: hold = reset & ~flush & ((accept & WAIT_CYCLES>0) | (state==WAIT & counter>1)).
  - The PC is therefore held for exactly WAIT_CYCLES edges after acceptance.
  - The PC advances on the edge that moves the block into RESP.
- Latency and throughput:
  - valid=1 exactly WAIT_CYCLES+1 cycles after the accept cycle.
  - Throughput is one fetch per WAIT_CYCLES+1 cycles.
  - With WAIT_CYCLES=0, throughput is one fetch per cycle and hold is never asserted.
- Read sampling: the memory read is sampled on the edge entering RESP. `instruction` holds its value until the next completed fetch, reset, or fault.
- Faults:
  - misaligned: instruction = NOP_WORD, misaligned=1.
  - index >= DEPTH: instruction = NOP_WORD, out_of_range=1.
  - Both conditions may be set together. Both flags clear with valid.
- Flush:
  - flush=1 at an edge in IDLE, WAIT or RESP returns the block to IDLE with no valid on the next cycle.
  - flush=1 forces hold=0 in the same cycle, so the PC loads its target.
  - flush wins over a simultaneous req; that request is not accepted.
  - A valid already on the outputs in the flush cycle is not retracted.
- Reset mid-fetch: the fetch is discarded and no valid is produced.
- Writes:
  - wr_en writes mem[wr_addr index] at posedge, independent of FSM state and of reset (preload under reset is supported).
  - Writes with index >= DEPTH are dropped.
  - A write and a fetch read of the same word on the same edge: the read returns the old word.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, WAIT, RESP);
  - NOP_WORD;
  - the word-index extraction width, $clog2(DEPTH).
- Sub-module `imem_array`: DEPTH x 32 storage with one synchronous write port and one read port sampled on a read-enable edge. It gives old-data-on-collision behaviour by construction.

Test Plan:
- Preload mem[0..3] = 0x11,0x22,0x33,0x44 under reset=0, then release; req=1 with address 0x0 (WAIT_CYCLES=2):
  - hold=1 for 2 cycles;
  - valid=1 with instruction=0x11 in the 3rd cycle after accept.
- PC-style increment loop over 0x0,0x4,0x8,0xC: four valids carrying 0x11,0x22,0x33,0x44, spaced 3 cycles apart, with no repeats or skips.
- WAIT_CYCLES=0 build, same loop: valid every cycle, hold never asserted, data in order.
- address 0x6 → instruction=NOP_WORD, misaligned=1. address 0x100 (DEPTH=64) → NOP_WORD, out_of_range=1.
- flush=1 in the first WAIT cycle of a fetch to 0x4:
  - hold=0 that cycle;
  - no valid for 0x4;
  - the following req to 0x8 returns 0x33.
- reset=0 during WAIT: the next cycle shows valid=0, instruction=NOP_WORD, hold=0. A write to word 2 on the completion edge of a fetch of 0x8 returns the old value 0x33.
